// File: rtl/enc_pkg.sv
// enc_pkg: shared mode constants, FSM state type, parameter limits and quadrature decoder
package enc_pkg;
   localparam logic MODE_EDGE = 1'b0;
   localparam logic MODE_QUAD = 1'b1;
   localparam int N_CH_MIN = 1;
   localparam int N_CH_MAX = 16;
   localparam int CNT_W_MIN = 8;
   localparam int CNT_W_MAX = 64;
   localparam int SYNC_MIN = 2;
   localparam int SYNC_MAX = 4;
   typedef enum logic {IDLE, ARMED} state_t;
   // {A,B} mapped to a 2-bit Gray position: 00->0, 10->1, 11->2, 01->3
   function automatic logic [1:0] quad_pos(input logic [1:0] ab);
      return {ab[0], ab[1] ^ ab[0]};
   endfunction
   // returns {err, dir(1=up), en}
   function automatic logic [2:0] quad_step(input logic [1:0] ab_prev, input logic [1:0] ab_now);
      logic [1:0] d;
      d = quad_pos(ab_now) - quad_pos(ab_prev);
      return {d == 2'd2, d == 2'd1, d[0]};
   endfunction
endpackage

// File: rtl/enc_in_filt.sv
// enc_in_filt: single-bit synchroniser and glitch filter with rise detect
module enc_in_filt
   import enc_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic d,
   output logic q,
   output logic rise
);
   logic [SYNC_STAGES-1:0] sync;
   logic q_d;
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         sync <= '0;
         q_d <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], d};
         q_d <= q;
      end
   assign rise = q & ~q_d;
   if (FILT_LEN == 0) begin : g_bypass
      assign q = sync[SYNC_STAGES-1];
   end else begin : g_filt
      localparam int CW = $clog2(FILT_LEN + 1);
      logic [CW-1:0] run;
      logic lvl;
      // lvl flips once the synced level has differed for FILT_LEN consecutive cycles
      always_ff @(posedge CLK or posedge RST)
         if (RST) begin
            run <= '0;
            lvl <= 1'b0;
         end else if (sync[SYNC_STAGES-1] == lvl) run <= '0;
         else if (run == CW'(FILT_LEN - 1)) begin
            run <= '0;
            lvl <= ~lvl;
         end else run <= run + 1'b1;
      assign q = lvl;
   end
endmodule

// File: rtl/enc_cnt_multi.sv
// enc_cnt_multi: multi-channel incremental-encoder counter with index clear, latch and sticky flags
module enc_cnt_multi
   import enc_pkg::*;
#(
   parameter int N_CH = 2,
   parameter int CNT_W = 64,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN = 4,
   parameter int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  I_ARM,
   input  logic                  I_MODE,
   input  logic [SEL_W-1:0]      I_SEL,
   input  logic [N_CH-1:0]       I_A,
   input  logic [N_CH-1:0]       I_B,
   input  logic [N_CH-1:0]       I_Z,
   output logic [N_CH*CNT_W-1:0] O_CNT,
   output logic [N_CH*CNT_W-1:0] O_Z_LATCH,
   output logic                  O_ZEVT,
   output logic [N_CH-1:0]       O_OVF,
   output logic [N_CH-1:0]       O_ERR
);
   if (N_CH < N_CH_MIN || N_CH > N_CH_MAX || CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX ||
       SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX || FILT_LEN < 0) begin : g_bad_param
      $error("enc_cnt_multi: parameter out of range");
   end
   state_t state, state_nxt;
   logic [N_CH-1:0] a_f, b_f, z_f, a_r, b_r, z_r, a_p, b_p, up, dn, qe, wrap;
   logic [CNT_W-1:0] cnt [N_CH];
   logic [CNT_W-1:0] lat [N_CH];
   logic [CNT_W-1:0] nxt [N_CH];
   logic [2:0] st [N_CH];
   logic arm_d, arm_rise, run, zevt, mode_q, quad;
   logic unused_lvl;
   assign unused_lvl = ^{b_r, z_f};
   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      enc_in_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_a (
         .CLK(CLK), .RST(RST), .d(I_A[k]), .q(a_f[k]), .rise(a_r[k]));
      enc_in_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_b (
         .CLK(CLK), .RST(RST), .d(I_B[k]), .q(b_f[k]), .rise(b_r[k]));
      enc_in_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_z (
         .CLK(CLK), .RST(RST), .d(I_Z[k]), .q(z_f[k]), .rise(z_r[k]));
      assign O_CNT[k*CNT_W +: CNT_W] = cnt[k];
      assign O_Z_LATCH[k*CNT_W +: CNT_W] = lat[k];
   end
   always_ff @(posedge CLK or posedge RST)
      if (RST) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      arm_rise = I_ARM & ~arm_d;
      run = state == ARMED;
      state_nxt = run ? (I_ARM ? ARMED : IDLE) : (arm_rise ? ARMED : IDLE);
      zevt = run && int'(I_SEL) < N_CH && z_r[I_SEL];
   end
   assign quad = mode_q == MODE_QUAD;
   always_comb
      for (int k = 0; k < N_CH; k++) begin
         st[k] = quad_step({a_p[k], b_p[k]}, {a_f[k], b_f[k]});
         up[k] = run && (quad ? st[k][1] : a_r[k]);
         dn[k] = run && quad && st[k][0] && !st[k][1];
         qe[k] = run && quad && st[k][2];
         nxt[k] = up[k] ? cnt[k] + 1'b1 : dn[k] ? cnt[k] - 1'b1 : cnt[k];
         wrap[k] = (up[k] && &cnt[k]) || (dn[k] && ~|cnt[k]);
      end
   // arm_d resets high so an I_ARM already high at reset release is not taken as a rising edge
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         arm_d <= 1'b1;
         mode_q <= MODE_EDGE;
         a_p <= '0;
         b_p <= '0;
         O_ZEVT <= 1'b0;
         O_OVF <= '0;
         O_ERR <= '0;
         for (int k = 0; k < N_CH; k++) begin
            cnt[k] <= '0;
            lat[k] <= '0;
         end
      end else begin
         arm_d <= I_ARM;
         a_p <= a_f;
         b_p <= b_f;
         O_ZEVT <= zevt;
         if (arm_rise) mode_q <= I_MODE;
         O_OVF <= arm_rise ? '0 : O_OVF | wrap;
         O_ERR <= arm_rise ? '0 : O_ERR | qe;
         for (int k = 0; k < N_CH; k++) begin
            cnt[k] <= (arm_rise || zevt) ? '0 : nxt[k];
            if (zevt) lat[k] <= nxt[k];
         end
      end
endmodule

// File: tb/tb_enc_cnt_multi.sv
// tb_enc_cnt_multi: directed and randomized self-checking bench for enc_cnt_multi
module tb_enc_cnt_multi;
   import enc_pkg::*;
   logic CLK = 1'b0, RST = 1'b1, I_ARM = 1'b0, I_MODE = 1'b0;
   logic [0:0] I_SEL = 1'b0;
   logic [1:0] I_A = '0, I_B = '0, I_Z = '0;
   logic [127:0] O_CNT, O_Z_LATCH;
   logic O_ZEVT;
   logic [1:0] O_OVF, O_ERR;
   int n_chk = 0, n_fail = 0, zc;
   int pos [2] = '{0, 0};
   logic [63:0] cnt_m [2];
   logic [63:0] lat_m [2];
   logic [1:0] ovf_m, err_m;

   enc_cnt_multi #(.N_CH(2), .CNT_W(64), .SYNC_STAGES(2), .FILT_LEN(4)) dut (
      .CLK(CLK), .RST(RST), .I_ARM(I_ARM), .I_MODE(I_MODE), .I_SEL(I_SEL),
      .I_A(I_A), .I_B(I_B), .I_Z(I_Z), .O_CNT(O_CNT), .O_Z_LATCH(O_Z_LATCH),
      .O_ZEVT(O_ZEVT), .O_OVF(O_OVF), .O_ERR(O_ERR));

   always #5 CLK = ~CLK;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic arm(input logic mode);
      I_ARM = 1'b0;
      tick(2);
      I_MODE = mode;
      I_ARM = 1'b1;
      tick(1);
      cnt_m[0] = '0;
      cnt_m[1] = '0;
      ovf_m = '0;
      err_m = '0;
   endtask

   task automatic pulse(input int ch, input bit live);
      I_A[ch] = 1'b1;
      I_B[ch] = 1'($urandom_range(0, 1));
      tick(8);
      I_A[ch] = 1'b0;
      tick(8);
      if (live) cnt_m[ch] = cnt_m[ch] + 64'd1;
   endtask

   task automatic qstep(input int ch, input int dir);
      if ((dir > 0 && cnt_m[ch] == '1) || (dir < 0 && cnt_m[ch] == '0)) ovf_m[ch] = 1'b1;
      cnt_m[ch] = dir > 0 ? cnt_m[ch] + 64'd1 : cnt_m[ch] - 64'd1;
      pos[ch] = (pos[ch] + dir + 4) % 4;
      I_A[ch] = pos[ch] == 1 || pos[ch] == 2;
      I_B[ch] = pos[ch] >= 2;
      tick(8);
   endtask

   task automatic watch_zevt(input int n, output int c);
      c = 0;
      repeat (n) begin
         tick(1);
         c += int'(O_ZEVT);
      end
   endtask

   initial begin
      tick(3);
      chk("rst cnt", O_CNT, '0);
      chk("rst latch", O_Z_LATCH, '0);
      chk("rst zevt", 128'(O_ZEVT), '0);
      chk("rst ovf", 128'(O_OVF), '0);
      chk("rst err", 128'(O_ERR), '0);
      RST = 1'b0;
      tick(2);
      // mode 0 on ch0; a later I_MODE change must not matter until re-arm
      arm(MODE_EDGE);
      I_MODE = MODE_QUAD;
      I_A[0] = 1'b1;
      tick(6);
      chk("t1 latency before", O_CNT, '0);
      tick(1);
      chk("t1 latency at 7", O_CNT, 128'd1);
      tick(1);
      I_A[0] = 1'b0;
      tick(8);
      cnt_m[0] = 64'd1;
      repeat (9) pulse(0, 1'b1);
      chk("t1 ten pulses", O_CNT, {cnt_m[1], cnt_m[0]});
      chk("t1 ch0 is 10", 128'(O_CNT[63:0]), 128'd10);
      I_B[0] = 1'b0;
      tick(8);
      // quadrature on ch1
      arm(MODE_QUAD);
      repeat (12) qstep(1, 1);
      repeat (5) qstep(1, -1);
      chk("t2 12 fwd 5 rev", O_CNT, {cnt_m[1], cnt_m[0]});
      repeat (16) qstep(1, $urandom_range(0, 1) ? 1 : -1);
      chk("t2 random walk", O_CNT, {cnt_m[1], cnt_m[0]});
      chk("t2 random ovf", 128'(O_OVF), 128'(ovf_m));
      arm(MODE_QUAD);
      repeat (3) qstep(1, -1);
      chk("t2 wrap down", O_CNT, {cnt_m[1], cnt_m[0]});
      chk("t2 wrap value", 128'(O_CNT[127:64]), 128'(64'hFFFF_FFFF_FFFF_FFFD));
      chk("t2 ovf", 128'(O_OVF), 128'(ovf_m));
      // glitches shorter than the filter and a both-bits quadrature jump
      arm(MODE_EDGE);
      repeat (4) begin
         I_A[0] = 1'b1;
         tick($urandom_range(1, 3));
         I_A[0] = 1'b0;
         tick(10);
      end
      chk("t3 glitch dropped", O_CNT, '0);
      arm(MODE_QUAD);
      I_A[0] = 1'b1;
      I_B[0] = 1'b1;
      pos[0] = 2;
      err_m[0] = 1'b1;
      tick(8);
      chk("t3 err flag", 128'(O_ERR), 128'(err_m));
      chk("t3 err no count", O_CNT, {cnt_m[1], cnt_m[0]});
      I_A[0] = 1'b0;
      I_B[0] = 1'b0;
      pos[0] = 0;
      tick(8);
      // index on channel 1
      arm(MODE_QUAD);
      I_SEL = 1'b1;
      repeat (20) qstep(0, 1);
      repeat (9) qstep(1, 1);
      chk("t4 pre-index", O_CNT, {64'd9, 64'd20});
      I_Z[1] = 1'b1;
      tick(6);
      chk("t4 zevt early", 128'(O_ZEVT), '0);
      tick(1);
      lat_m = cnt_m;
      cnt_m[0] = '0;
      cnt_m[1] = '0;
      chk("t4 zevt", 128'(O_ZEVT), 128'd1);
      chk("t4 latch", O_Z_LATCH, {lat_m[1], lat_m[0]});
      chk("t4 cleared", O_CNT, {cnt_m[1], cnt_m[0]});
      tick(1);
      chk("t4 zevt one cycle", 128'(O_ZEVT), '0);
      I_Z[1] = 1'b0;
      tick(8);
      I_Z[0] = 1'b1;
      watch_zevt(16, zc);
      I_Z[0] = 1'b0;
      tick(8);
      chk("t4 z0 ignored", 128'(zc), '0);
      chk("t4 latch kept", O_Z_LATCH, {lat_m[1], lat_m[0]});
      // A edge coincident with an accepted Z edge
      arm(MODE_EDGE);
      repeat (4) pulse(0, 1'b1);
      I_A[0] = 1'b1;
      I_Z[1] = 1'b1;
      cnt_m[0] = cnt_m[0] + 64'd1;
      tick(7);
      lat_m = cnt_m;
      cnt_m[0] = '0;
      cnt_m[1] = '0;
      chk("t5 latch with delta", O_Z_LATCH, {lat_m[1], lat_m[0]});
      chk("t5 latch ch0 is 5", 128'(O_Z_LATCH[63:0]), 128'd5);
      chk("t5 cleared", O_CNT, '0);
      tick(1);
      I_A[0] = 1'b0;
      I_Z[1] = 1'b0;
      tick(8);
      // arm rising edge on the same cycle as a filtered Z rise
      I_ARM = 1'b0;
      tick(2);
      I_Z[1] = 1'b1;
      tick(6);
      I_ARM = 1'b1;
      watch_zevt(10, zc);
      chk("t5 arm beats z", 128'(zc), '0);
      chk("t5 latch kept", O_Z_LATCH, {lat_m[1], lat_m[0]});
      I_Z[1] = 1'b0;
      tick(8);
      // async reset mid-count with I_ARM held high
      repeat (33) pulse(0, 1'b1);
      chk("t6 ch0 is 33", O_CNT, {cnt_m[1], cnt_m[0]});
      RST = 1'b1;
      #1;
      chk("t6 rst cnt", O_CNT, '0);
      chk("t6 rst latch", O_Z_LATCH, '0);
      chk("t6 rst flags", 128'({O_ZEVT, O_OVF, O_ERR}), '0);
      cnt_m[0] = '0;
      cnt_m[1] = '0;
      tick(2);
      RST = 1'b0;
      tick(2);
      repeat (3) pulse(0, 1'b0);
      chk("t6 no count after rst", O_CNT, '0);
      arm(MODE_EDGE);
      repeat (2) pulse(0, 1'b1);
      chk("t6 re-armed", O_CNT, {cnt_m[1], cnt_m[0]});
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/enc_cnt_multi.md
Name: enc_cnt_multi

Overview:
Parametrised multi-channel incremental-encoder counter for the DAQ front end. It is the successor to the fixed two-channel A-edge counter.
- Adds input synchronisation and glitch filtering per signal.
- Adds an x4 quadrature up/down mode, a run-time-selectable index (Z) channel that clears all counters, an index latch, and sticky overflow/error flags.
- Sits between the encoder pins and the acquisition/readout logic.

Parameters:
N_CH, 2, number of encoder channels (1..16)
CNT_W, 64, counter width per channel (8..64)
SYNC_STAGES, 2, input synchroniser depth (2..4)
FILT_LEN, 4, consecutive stable cycles needed to accept a new input level (0 = filter bypassed)
SEL_W, $clog2(N_CH) min 1, derived width of I_SEL

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-high reset
I_ARM  in  1  count enable; its rising edge clears counters and flags
I_MODE  in  1  0 = count A rising edges (up only); 1 = x4 quadrature up/down
I_SEL  in  SEL_W  index channel whose Z clears all counters
I_A  in  N_CH  phase A per channel
I_B  in  N_CH  phase B per channel (ignored in mode 0)
I_Z  in  N_CH  index pulse per channel
O_CNT  out  N_CH*CNT_W  packed counters; channel k at [k*CNT_W +: CNT_W]
O_Z_LATCH  out  N_CH*CNT_W  counters captured at the last accepted index event
O_ZEVT  out  1  one-cycle pulse per accepted index event
O_OVF  out  N_CH  sticky wrap flag per channel
O_ERR  out  N_CH  sticky quadrature error per channel (both A and B changed in one cycle)

Behaviour:
- Reset (RST=1, async): O_CNT=0, O_Z_LATCH=0, O_ZEVT=0, O_OVF=0, O_ERR=0, state IDLE, filter/sync regs=0, latched mode=0.
- Input path, per A/B/Z bit:
  - SYNC_STAGES flops, then filter.
  - Filter output takes the synced level after FILT_LEN consecutive cycles differing from the current output.
  - FILT_LEN=0: filter output = synced level.
  - Pulses shorter than FILT_LEN cycles are dropped.
- Latency: pin change to O_CNT update is exactly SYNC_STAGES + FILT_LEN + 1 CLK edges.
- FSM, 2 states:
  - IDLE -> ARMED on I_ARM rising edge, sampled on CLK. In the same cycle: O_CNT, O_OVF, O_ERR cleared; I_MODE latched. O_Z_LATCH is kept.
  - ARMED -> IDLE when I_ARM=0. Counters and flags hold; edges and Z are ignored.
  - I_MODE changes while ARMED have no effect until the next arm.
- Mode 0: +1 on each filtered A rising edge.
- Mode 1 (per-cycle {A,B} transitions):
  - +1 for 00->10, 10->11, 11->01, 01->00 (A leads B).
  - -1 for the reverse transitions.
  - No change when the state is unchanged.
  - Both bits changed: no count, O_ERR[k] set.
- Wrap:
  - Up from 2^CNT_W-1 gives 0 and sets O_OVF[k].
  - Down from 0 gives 2^CNT_W-1 and sets O_OVF[k].
  - Flags stay set until the next arm or reset.
- Index event = filtered rising edge of I_Z[I_SEL] while ARMED. I_SEL is sampled each cycle; I_SEL >= N_CH means no index source. Same cycle as the event:
  - O_Z_LATCH[k] = count including that cycle's delta.
  - O_CNT[k] = 0 for all k; the coincident delta is not added after the clear.
  - O_ZEVT = 1 for exactly one cycle.
- Arm rising edge coincident with Z edge: arm clear wins; no O_ZEVT, no latch.
- RST asserted mid-count: immediate return to reset values. After RST release, a fresh I_ARM rising edge is needed to count. If I_ARM is already high at release, no count occurs until it goes low and high again.

Decomposition:
- Package enc_pkg:
  - Mode constants MODE_EDGE=0, MODE_QUAD=1.
  - FSM state typedef (IDLE, ARMED).
  - Function quad_step({A,B}_prev, {A,B}_now) returning {err, dir, en}.
  - Parameter range limits.
- Sub-module enc_in_filt: one bit, SYNC_STAGES + FILT_LEN, outputs the filtered level plus a registered rise pulse. Instantiated 3*N_CH times.
- Top holds the FSM, counters, latch and flags.

Test Plan:
1. Defaults, mode 0. Arm, then 10 clean A pulses on ch0 (each level held 8 cycles) -> O_CNT ch0=10, ch1=0. First increment exactly 7 edges after the first A rise.
2. Mode 1, ch1. 12 forward quadrature steps then 5 reverse -> O_CNT ch1=7. Then 3 reverse steps from a fresh arm -> ch1=2^64-3 with O_OVF[1]=1.
3. Glitch. 3-cycle A pulses with FILT_LEN=4 -> no count. One {A,B} 00->11 step within one cycle in mode 1 -> O_ERR=1, count unchanged.
4. Index. I_SEL=1, counts ch0=20 and ch1=9, Z1 rising edge -> O_Z_LATCH={9,20}, O_CNT=0, one-cycle O_ZEVT. A Z0 edge afterwards -> no effect.
5. Coincidence. A edge on the same cycle as an accepted Z with ch0=4 -> O_Z_LATCH ch0=5, O_CNT ch0=0. Arm rising edge on the same cycle as a Z edge -> no O_ZEVT.
6. RST pulse mid-count (ch0=33) with I_ARM held high -> all outputs 0. Edges ignored until I_ARM goes low and then high again.
